// File: rtl/int_to_float_unit.sv
// Multi-cycle 32-bit integer to IEEE-754 single-precision converter.
// A one-bit-per-cycle normalizing shifter feeds a single rounding step; valid/ready on both sides.
module int_to_float_unit #(
  parameter int SIGNED_IN  = 1,
  parameter int ROUND_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] EXP_TOP = 8'd158;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] mag_r;
  logic [31:0] mag_s;
  logic [7:0]  exp_r;
  logic [7:0]  exp_s;
  logic        sign_r;
  logic        sign_s;
  logic [31:0] out_data_r;
  logic [31:0] data_s;
  logic        out_inexact_r;
  logic        inexact_s;
  logic        out_valid_r;
  logic        in_ready_r;

  logic        op_sign_s;
  logic [31:0] op_mag_s;
  logic [22:0] rnd_frac_s;
  logic        rnd_g_s;
  logic        rnd_s_s;
  logic [22:0] rnd_sum_s;
  logic        rnd_carry_s;

  // Round-to-nearest-even increments on guard set with sticky or odd lsb; truncate never does.
  function automatic logic round_up_f(input logic [22:0] frac, input logic g, input logic s);
    return (ROUND_MODE == 32'sd0) && g && (s || frac[0]);
  endfunction

  // Next-state, datapath and result computation.
  always_comb begin
    state_s   = state_r;
    mag_s     = mag_r;
    exp_s     = exp_r;
    sign_s    = sign_r;
    data_s    = out_data_r;
    inexact_s = out_inexact_r;

    op_sign_s  = (SIGNED_IN != 32'sd0) && in_data[31];
    op_mag_s   = op_sign_s ? (32'd0 - in_data) : in_data;
    rnd_frac_s = mag_r[30:8];
    rnd_g_s    = mag_r[7];
    rnd_s_s    = |mag_r[6:0];
    {rnd_carry_s, rnd_sum_s} = {1'b0, rnd_frac_s} +
                               {23'd0, round_up_f(rnd_frac_s, rnd_g_s, rnd_s_s)};

    case (state_r)
      IDLE: begin
        if (in_valid) begin
          sign_s = op_sign_s;
          mag_s  = op_mag_s;
          exp_s  = EXP_TOP;
          if (op_mag_s == 32'd0) begin
            data_s    = 32'd0;
            inexact_s = 1'b0;
            state_s   = DONE;
          end else if (op_mag_s[31]) begin
            // Already normalized: skip the shifter entirely.
            state_s = ROUND;
          end else begin
            state_s = NORM;
          end
        end else begin
          state_s = IDLE;
        end
      end
      NORM: begin
        mag_s = {mag_r[30:0], 1'b0};
        exp_s = exp_r - 8'd1;
        // Leave as soon as this shift brings the leading one to the top.
        if (mag_r[30]) begin
          state_s = ROUND;
        end else begin
          state_s = NORM;
        end
      end
      ROUND: begin
        // A carry out of the fraction leaves it zero and bumps the exponent.
        data_s    = {sign_r, exp_r + {7'd0, rnd_carry_s}, rnd_sum_s};
        inexact_s = rnd_g_s | rnd_s_s;
        state_s   = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      mag_r         <= 32'd0;
      exp_r         <= 8'd0;
      sign_r        <= 1'b0;
      out_data_r    <= 32'd0;
      out_inexact_r <= 1'b0;
      out_valid_r   <= 1'b0;
      in_ready_r    <= 1'b1;
    end else begin
      state_r       <= state_s;
      mag_r         <= mag_s;
      exp_r         <= exp_s;
      sign_r        <= sign_s;
      out_data_r    <= data_s;
      out_inexact_r <= inexact_s;
      out_valid_r   <= (state_s == DONE);
      in_ready_r    <= (state_s == IDLE);
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_inexact = out_inexact_r;

endmodule

// File: tb/tb_int_to_float_unit.sv
// Self-checking bench for int_to_float_unit: directed spec cases plus random operands
// against an arithmetic reference model, on three parameterizations.
module tb_int_to_float_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid    [3];
  logic        in_ready    [3];
  logic [31:0] in_data     [3];
  logic        out_valid   [3];
  logic        out_ready   [3];
  logic [31:0] out_data    [3];
  logic        out_inexact [3];

  int checks   = 0;
  int failures = 0;

  // unit 0: signed, RNE; unit 1: signed, truncate; unit 2: unsigned, RNE
  int_to_float_unit #(.SIGNED_IN(1), .ROUND_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_inexact(out_inexact[0]));
  int_to_float_unit #(.SIGNED_IN(1), .ROUND_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_inexact(out_inexact[1]));
  int_to_float_unit #(.SIGNED_IN(0), .ROUND_MODE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .out_inexact(out_inexact[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: value = mag * 2^0, expressed as 1.f * 2^p, then rounded at 24 significant bits.
  function automatic void ref_conv(input logic [31:0] v, input bit sgn_in, input bit trunc,
                                   output logic [31:0] res, output logic inx, output int lat);
    bit neg;
    longint unsigned mag, q, rem, half;
    int p, sh, e;
    neg = sgn_in && v[31];
    mag = neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    if (mag == 64'd0) begin
      res = 32'd0;
      inx = 1'b0;
      lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (((mag >> i) & 64'd1) != 64'd0) p = i;
    e   = 127 + p;
    lat = (31 - p) + 2;
    rem = 64'd0;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      if (!trunc && (rem > half || (rem == half && q[0]))) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    res = {neg, e[7:0], q[22:0]};
    inx = (rem != 64'd0);
  endfunction

  task automatic run(input int u, input logic [31:0] v, input int hold,
                     input bit use_exp, input logic [31:0] exp_d, input logic exp_x);
    logic [31:0] rd;
    logic        rx;
    int          rl;
    int          lat;
    string       tg;
    ref_conv(v, (u != 2), (u == 1), rd, rx, rl);
    tg = $sformatf("u%0d_%08h", u, v);
    @(negedge clk);
    check({tg, "_in_ready_idle"}, 32'(in_ready[u]), 32'd1);
    in_data[u]   = v;
    in_valid[u]  = 1'b1;
    out_ready[u] = 1'b0;
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
    in_data[u]  = $urandom;
    lat = 1;
    while (out_valid[u] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      in_data[u] = $urandom;
      lat++;
    end
    check({tg, "_latency"}, 32'(lat), 32'(rl));
    check({tg, "_data"}, out_data[u], rd);
    check({tg, "_inexact"}, 32'(out_inexact[u]), 32'(rx));
    if (use_exp) begin
      check({tg, "_data_known"}, out_data[u], exp_d);
      check({tg, "_inexact_known"}, 32'(out_inexact[u]), 32'(exp_x));
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      in_data[u]  = $urandom;
      in_valid[u] = 1'b1;
      check({tg, "_hold_data"}, out_data[u], rd);
      check({tg, "_hold_valid"}, 32'(out_valid[u]), 32'd1);
      check({tg, "_hold_in_ready"}, 32'(in_ready[u]), 32'd0);
    end
    @(negedge clk);
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[u] = 1'b0;
    check({tg, "_release_in_ready"}, 32'(in_ready[u]), 32'd1);
    check({tg, "_release_valid"}, 32'(out_valid[u]), 32'd0);
  endtask

  initial begin
    logic [31:0] d_val [8];
    logic [31:0] d_exp [8];
    logic        d_inx [8];
    logic [31:0] v;
    bit          seen;

    d_val = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000,
              32'd16777217, 32'd16777219, 32'h7FFF_FFFF, 32'd5};
    d_exp = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'hCF00_0000,
              32'h4B80_0000, 32'h4B80_0002, 32'h4F00_0000, 32'h40A0_0000};
    d_inx = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      in_valid[u]  = 1'b0;
      in_data[u]   = 32'd0;
      out_ready[u] = 1'b0;
    end
    #12;
    check("reset_in_ready", 32'(in_ready[0]), 32'd1);
    check("reset_out_valid", 32'(out_valid[0]), 32'd0);
    check("reset_out_data", out_data[0], 32'd0);
    check("reset_out_inexact", 32'(out_inexact[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run(0, d_val[i], 0, 1'b1, d_exp[i], d_inx[i]);

    run(1, 32'd16777219, 0, 1'b1, 32'h4B80_0001, 1'b1);
    run(2, 32'hFFFF_FFFF, 0, 1'b1, 32'h4F80_0000, 1'b1);

    // Backpressure: result must hold for 5 stalled cycles.
    run(0, 32'h1234_5678, 5, 1'b0, 32'd0, 1'b0);

    // Reset during normalization discards the conversion.
    @(negedge clk);
    in_data[0]  = 32'd1;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid[0] === 1'b1) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    run(0, 32'd5, 0, 1'b1, 32'h40A0_0000, 1'b0);

    for (int i = 0; i < 64; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
      run(i % 3, v, $urandom_range(0, 2), 1'b0, 32'd0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
